// File: rtl/dispatch_sequencer.sv
// dispatch_sequencer: buffers fetched instruction words and presents them to
// decode one micro-op per cycle. LDP/STP are cracked into two ordered uops,
// a dispatched HLT stops the front end, and a flush discards buffered work.
//
// Ports:
//   in_clk, in_rst_n        clock, synchronous active-low reset
//   in_flush                clears FIFO, cracking state and halt
//   in_fetch_valid/insnbits fetch offer; out_fetch_ready accepts it
//   out_dec_valid/insnbits  head micro-op to decode; out_dec_uop: 00 single,
//                           01 pair first half, 10 pair second half
//   in_dec_ready, in_stall  decode handshake and core stall
//   out_count, out_halted   FIFO occupancy and halt status
`ifndef INSNBITS_SIZE
`define INSNBITS_SIZE 32
`endif

module dispatch_sequencer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned INSN_W = `INSNBITS_SIZE
) (
  input  logic                       in_clk,
  input  logic                       in_rst_n,
  input  logic                       in_flush,
  input  logic                       in_fetch_valid,
  input  logic [INSN_W-1:0]          in_fetch_insnbits,
  output logic                       out_fetch_ready,
  output logic                       out_dec_valid,
  output logic [INSN_W-1:0]          out_dec_insnbits,
  output logic [1:0]                 out_dec_uop,
  input  logic                       in_dec_ready,
  input  logic                       in_stall,
  output logic [$clog2(DEPTH):0]     out_count,
  output logic                       out_halted
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {ST_RUN, ST_PAIR2, ST_HALT} state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    head_q, head_d;
  logic [PTR_W-1:0]    tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [INSN_W-1:0]   mem_q [DEPTH];
  logic [INSN_W-1:0]   mem_d [DEPTH];

  logic                not_empty;
  logic                halted;
  logic [INSN_W-1:0]   head_word;
  logic                head_pair;
  logic                head_hlt;
  logic                push;
  logic                fire;
  logic                pop;

  // Head decode: paired memory ops crack, HLT stops the front end
  always_comb begin
    head_word = mem_q[head_q];
    head_pair = (head_word[31:22] == 10'b10_1010_0011) ||
                (head_word[31:22] == 10'b10_1010_0100);
    head_hlt  = (head_word[31:21] == 11'b110_1010_0010) &&
                (head_word[4:0] == 5'd0);
  end

  // Handshake outputs depend only on registered state plus stall/reset
  always_comb begin
    not_empty       = (count_q != CNT_W'(0));
    halted          = (state_q == ST_HALT);
    out_dec_valid   = not_empty & ~halted & ~in_stall & in_rst_n;
    out_fetch_ready = in_rst_n & ~halted & (count_q < CNT_W'(DEPTH));
    out_count       = count_q;
    out_halted      = halted;
    out_dec_insnbits = '0;
    out_dec_uop      = 2'b00;
    if (not_empty && in_rst_n) begin
      out_dec_insnbits = head_word;
      if (state_q == ST_PAIR2)                out_dec_uop = 2'b10;
      else if (state_q == ST_RUN && head_pair) out_dec_uop = 2'b01;
    end
  end

  // Next state: FIFO pointers/occupancy and cracking FSM; flush wins
  always_comb begin
    push    = in_fetch_valid & out_fetch_ready;
    fire    = out_dec_valid & in_dec_ready & ~in_stall;
    // First half of a pair leaves the word at the head for the second half
    pop     = fire & ((state_q == ST_PAIR2) || (state_q == ST_RUN && !head_pair));
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mem_d   = mem_q;

    if (push) begin
      mem_d[tail_q] = in_fetch_insnbits;
      tail_d        = tail_q + PTR_W'(1);
    end
    if (pop) head_d = head_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      ST_RUN: begin
        if (fire) begin
          if (head_pair)     state_d = ST_PAIR2;
          else if (head_hlt) state_d = ST_HALT;
        end
      end
      ST_PAIR2: if (fire) state_d = ST_RUN;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_RUN;
    endcase

    if (in_flush) begin
      state_d = ST_RUN;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      state_q <= ST_RUN;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

endmodule
